// File: rtl/spi_byte_sequencer_pkg.sv
// Shared FSM state type, default byte width and a constant-foldable ceil-log2
// for the SPI byte sequencer and its FIFOs.
package spi_seq_pkg;

   localparam int DEF_DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      LAUNCH,
      WAIT_ACK,
      WAIT_DONE,
      STORE
   } seq_state_t;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/spi_byte_sequencer_fifo.sv
// First-word-fall-through FIFO, DEPTH a power of two; head visible with zero latency.
// Push is refused when full unless a pop happens in the same cycle; flush empties it in one cycle.
module spi_seq_fifo
   import spi_seq_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  push,
   input  logic [WIDTH-1:0]      push_dat,
   input  logic                  pop,
   output logic [WIDTH-1:0]      pop_dat,
   output logic                  full,
   output logic                  empty,
   output logic [clog2(DEPTH):0] count
);

   localparam int AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign pop_dat = mem[rd_ptr];

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + (AW+1)'(1);
         else if (do_pop && !do_push) count <= count - (AW+1)'(1);
      end
   end

   always_ff @(posedge sys_clk) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

endmodule

// File: rtl/spi_byte_sequencer.sv
// Feeds host bytes one at a time to an SPI master and queues the replies; SPI_SEQ_TIMEOUT_EN adds a per-byte watchdog.
// At least 5 sys_clk per byte plus master time; tx_ready/rx_valid handshakes, launches stall while RX cannot take a reply.
module spi_byte_sequencer
   import spi_seq_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  sys_clk,
   input  logic                  rst_n,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic [DATA_WIDTH-1:0] tx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  busy,
   output logic                  m_start,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_recv_vld,
   input  logic [DATA_WIDTH-1:0] m_recv_data,
   output logic                  timeout_err
);

   localparam int CW = clog2(FIFO_DEPTH) + 1;

   seq_state_t            state;
   logic                  vld_q;
   logic                  tx_full;
   logic                  tx_empty;
   logic                  rx_full;
   logic                  rx_empty;
   logic [CW-1:0]         tx_count;
   logic [CW-1:0]         rx_count;
   logic [DATA_WIDTH-1:0] tx_head;
   logic                  tx_flush;
   logic                  to_hit;
   logic                  can_launch;
   logic                  can_chain;
   logic                  unused_status;

   assign tx_ready      = !tx_full;
   assign rx_valid      = !rx_empty;
   assign busy          = (state != IDLE);
   assign can_launch    = !tx_empty && !rx_full;
   // Leaving STORE, the RX slot being filled right now must not be counted as room.
   assign can_chain     = !tx_empty && (rx_count < CW'(FIFO_DEPTH - 1));
   assign tx_flush      = to_hit;
   assign unused_status = ^tx_count;

   spi_seq_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .flush    (tx_flush),
      .push     (tx_valid && tx_ready),
      .push_dat (tx_data),
      .pop      (state == LOAD),
      .pop_dat  (tx_head),
      .full     (tx_full),
      .empty    (tx_empty),
      .count    (tx_count)
   );

   spi_seq_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .sys_clk  (sys_clk),
      .rst_n    (rst_n),
      .flush    (1'b0),
      .push     (state == STORE),
      .push_dat (m_recv_data),
      .pop      (rx_ready),
      .pop_dat  (rx_data),
      .full     (rx_full),
      .empty    (rx_empty),
      .count    (rx_count)
   );

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         m_start <= 1'b0;
         m_data  <= '0;
         vld_q   <= 1'b0;
      end else begin
         vld_q <= m_recv_vld;
         case (state)
            IDLE: begin
               if (can_launch) state <= LOAD;
            end
            LOAD: begin
               m_data  <= tx_head;
               m_start <= 1'b1;
               state   <= LAUNCH;
            end
            LAUNCH: begin
               m_start <= 1'b0;
               state   <= WAIT_ACK;
            end
            WAIT_ACK: begin
               if (to_hit)           state <= IDLE;
               else if (!m_recv_vld) state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (to_hit)                     state <= IDLE;
               else if (m_recv_vld && !vld_q)  state <= STORE;
            end
            STORE: begin
               state <= can_chain ? LOAD : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SPI_SEQ_TIMEOUT_EN
   localparam int TW = clog2(TIMEOUT_CYCLES) + 1;

   logic [TW-1:0] to_cnt;
   logic          in_wait;

   assign in_wait = (state == WAIT_ACK) || (state == WAIT_DONE);
   assign to_hit  = in_wait && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == LAUNCH) to_cnt <= '0;
         else if (in_wait)    to_cnt <= to_cnt + TW'(1);
         if (to_hit) timeout_err <= 1'b1;
      end
   end
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;

   assign to_hit      = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_byte_sequencer.sv
// Randomized scoreboard bench for spi_byte_sequencer with a behavioural SPI master
// that answers each launched byte with (byte ^ mask).
`timescale 1ns/1ps
module tb_spi_byte_sequencer;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int TO    = 16;

   logic          sys_clk = 1'b0;
   logic          rst_n;
   logic          tx_valid;
   logic          tx_ready;
   logic [DW-1:0] tx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic [DW-1:0] rx_data;
   logic          busy;
   logic          m_start;
   logic [DW-1:0] m_data;
   logic          m_recv_vld;
   logic [DW-1:0] m_recv_data;
   logic          timeout_err;

   logic [DW-1:0] mask;
   bit            stuck;
   bit            slow;
   bit            rand_rdy;

   logic [DW-1:0] md_q[$];
   logic [DW-1:0] rx_q[$];
   int            launches = 0;
   int            checks   = 0;
   int            errors   = 0;

   always #5 sys_clk = ~sys_clk;

   spi_byte_sequencer #(
      .DATA_WIDTH     (DW),
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .sys_clk     (sys_clk),
      .rst_n       (rst_n),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_data     (tx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .rx_data     (rx_data),
      .busy        (busy),
      .m_start     (m_start),
      .m_data      (m_data),
      .m_recv_vld  (m_recv_vld),
      .m_recv_data (m_recv_data),
      .timeout_err (timeout_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event did not occur within its bound", name);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   // Expected launch byte and expected reply are queued when the push handshake is certain.
   task automatic push_byte(input logic [DW-1:0] b);
      int guard;
      guard    = 0;
      tx_valid = 1'b1;
      tx_data  = b;
      @(negedge sys_clk);
      while (!tx_ready && guard < 2000) begin
         @(negedge sys_clk);
         guard++;
      end
      if (!tx_ready) begin
         fail_now("push_accept");
      end else begin
         md_q.push_back(b);
         rx_q.push_back(b ^ mask);
      end
      @(posedge sys_clk);
      #1;
      tx_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int  n;
      bit  done;
      n    = 0;
      done = 1'b0;
      while (!done && n < 3000) begin
         @(negedge sys_clk);
         n++;
         done = (rx_q.size() == 0) && (md_q.size() == 0) && !busy && !rx_valid;
      end
      check({name, "_drained"}, 32'(done), 32'd1);
      @(posedge sys_clk);
      #1;
   endtask

   // SPI master: launch on falling edge of m_start, drop done, answer after a delay.
   initial begin
      logic [DW-1:0] sent;
      int unsigned   dly;
      m_recv_vld  = 1'b1;
      m_recv_data = '0;
      forever begin
         @(negedge sys_clk);
         if (rst_n && m_start) begin
            sent = m_data;
            @(posedge sys_clk);
            #1;
            m_recv_vld = 1'b0;
            while (stuck) begin
               @(posedge sys_clk);
               #1;
            end
            dly = slow ? 12 : $urandom_range(1, 6);
            repeat (dly) @(posedge sys_clk);
            #1;
            m_recv_data = sent ^ mask;
            m_recv_vld  = 1'b1;
         end
      end
   end

   // Monitor: every launch and every RX pop is matched against the scoreboard.
   initial begin
      forever begin
         @(negedge sys_clk);
         if (rst_n) begin
            if (m_start) begin
               launches++;
               if (md_q.size() == 0) fail_now("unexpected_launch");
               else check("m_data", 32'(m_data), 32'(md_q.pop_front()));
            end
            if (rx_valid && rx_ready) begin
               if (rx_q.size() == 0) fail_now("unexpected_rx");
               else check("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge sys_clk);
         #2;
         if (rand_rdy) rx_ready = ($urandom_range(0, 2) != 0);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int l0;
      int n;
      tx_valid = 1'b0;
      tx_data  = '0;
      rx_ready = 1'b0;
      mask     = '0;
      stuck    = 1'b0;
      slow     = 1'b0;
      rand_rdy = 1'b0;
      rst_n    = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge sys_clk);
      #1;
      check("rst_tx_ready", 32'(tx_ready), 32'd1);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_m_start", 32'(m_start), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);
      rst_n = 1'b1;
      wait_cycles(2);

      // Single byte, inverting master: expect reply 0x5A.
      mask     = 8'hFF;
      rx_ready = 1'b1;
      l0       = launches;
      push_byte(8'hA5);
      wait_drain("single");
      check("single_launches", 32'(launches - l0), 32'd1);

      // Four back-to-back bytes in loopback.
      mask = 8'h00;
      l0   = launches;
      for (int i = 1; i <= 4; i++) push_byte(8'(i));
      wait_drain("loopback");
      check("loopback_launches", 32'(launches - l0), 32'd4);

      // RX held off: four launches fill RX, the rest wait in TX.
      mask     = 8'h3C;
      rx_ready = 1'b0;
      l0       = launches;
      for (int i = 0; i < 6; i++) push_byte(8'(8'h10 + i));
      wait_cycles(80);
      check("stall_launches", 32'(launches - l0), 32'd4);
      check("stall_busy", 32'(busy), 32'd0);
      check("stall_rx_valid", 32'(rx_valid), 32'd1);
      check("stall_tx_ready", 32'(tx_ready), 32'd1);

      // Host push and pop in the same cycle while RX is full.
      tx_valid = 1'b1;
      tx_data  = 8'h77;
      rx_ready = 1'b1;
      @(negedge sys_clk);
      check("both_tx_ready", 32'(tx_ready), 32'd1);
      check("both_rx_valid", 32'(rx_valid), 32'd1);
      md_q.push_back(8'h77);
      rx_q.push_back(8'h77 ^ mask);
      @(posedge sys_clk);
      #1;
      tx_valid = 1'b0;
      rx_ready = 1'b0;
      @(negedge sys_clk);
      check("both_after_tx_ready", 32'(tx_ready), 32'd1);
      check("both_after_rx_valid", 32'(rx_valid), 32'd1);
      @(posedge sys_clk);
      #1;
      rx_ready = 1'b1;
      wait_drain("stall");
      check("stall_total_launches", 32'(launches - l0), 32'd7);

      // Random bytes, random gaps, random rx_ready.
      mask     = 8'($urandom);
      l0       = launches;
      rand_rdy = 1'b1;
      for (int i = 0; i < 24; i++) begin
         push_byte(8'($urandom));
         if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 8));
      end
      rand_rdy = 1'b0;
      rx_ready = 1'b1;
      wait_drain("random");
      check("random_launches", 32'(launches - l0), 32'd24);

      // Reset while the master is mid-byte.
      mask = 8'h0F;
      slow = 1'b1;
      l0   = launches;
      push_byte(8'hE1);
      push_byte(8'hE2);
      push_byte(8'hE3);
      n = 0;
      while (launches == l0 && n < 200) begin
         @(negedge sys_clk);
         n++;
      end
      check("midrst_launched", 32'(launches - l0), 32'd1);
      wait_cycles(4);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_m_start", 32'(m_start), 32'd0);
      check("midrst_m_data", 32'(m_data), 32'd0);
      check("midrst_tx_ready", 32'(tx_ready), 32'd1);
      check("midrst_rx_valid", 32'(rx_valid), 32'd0);
      check("midrst_timeout_err", 32'(timeout_err), 32'd0);
      md_q.delete();
      rx_q.delete();
      wait_cycles(3);
      rst_n = 1'b1;
      l0    = launches;
      wait_cycles(60);
      check("postrst_launches", 32'(launches - l0), 32'd0);
      check("postrst_rx_valid", 32'(rx_valid), 32'd0);
      check("postrst_busy", 32'(busy), 32'd0);
      slow = 1'b0;

`ifdef SPI_SEQ_TIMEOUT_EN
      // Master never finishes: watchdog flags, drops the queue, returns to IDLE.
      stuck = 1'b1;
      mask  = 8'h00;
      l0    = launches;
      push_byte(8'hC1);
      push_byte(8'hC2);
      push_byte(8'hC3);
      wait_cycles(6);
      check("to_early", 32'(timeout_err), 32'd0);
      wait_cycles(30);
      check("to_flag", 32'(timeout_err), 32'd1);
      check("to_busy", 32'(busy), 32'd0);
      check("to_tx_ready", 32'(tx_ready), 32'd1);
      check("to_rx_valid", 32'(rx_valid), 32'd0);
      check("to_launches", 32'(launches - l0), 32'd1);
      md_q.delete();
      rx_q.delete();
      stuck = 1'b0;
      wait_cycles(40);
      check("to_sticky", 32'(timeout_err), 32'd1);
      check("to_no_relaunch", 32'(launches - l0), 32'd1);
`else
      check("timeout_tied_low", 32'(timeout_err), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
